// File: rtl/pixel_gen_pkg.sv
// Shared encodings for the pixel stimulus source: output pattern modes and frame FSM states.
package pixel_gen_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_CONST = 2'd2,
        MODE_LFSR  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pixel_lfsr.sv
// Fibonacci-style shift register used as the pseudo-random pixel source; load wins over advance.
module pixel_lfsr #(
    parameter int unsigned          DATA_W    = 24,
    parameter logic [DATA_W-1:0]    LFSR_TAPS = 24'hE10000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_val,
    input  logic              advance,
    output logic [DATA_W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (advance) begin
            q <= {q[DATA_W-2:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/pixel_stream_gen.sv
// Frame-based pixel stimulus source with valid/ready handshake and sof/eol/eof framing.
module pixel_stream_gen
    import pixel_gen_pkg::*;
#(
    parameter int unsigned         CH_W      = 8,
    parameter int unsigned         IMG_W     = 16,
    parameter int unsigned         IMG_H     = 16,
    parameter int unsigned         CNT_MOD   = 4,
    parameter logic [3*CH_W-1:0]   LFSR_TAPS = 24'hE10000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [3*CH_W-1:0]   seed,
    input  logic                out_ready,
    output logic [3*CH_W-1:0]   d_out,
    output logic                d_valid,
    output logic                sof,
    output logic                eol,
    output logic                eof,
    output logic                busy,
    output logic                frame_done
);

    localparam int unsigned DATA_W = 3 * CH_W;
    localparam int unsigned XW     = $clog2(IMG_W);
    localparam int unsigned YW     = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [XW-1:0]     X_LAST   = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(IMG_H - 1);
    localparam logic [DATA_W-1:0] CNT_LAST = DATA_W'(CNT_MOD - 1);

    state_e              state;
    mode_e               mode_q;
    logic [XW-1:0]       x, nx;
    logic [YW-1:0]       y, ny;
    logic [DATA_W-1:0]   pix_q, next_pix, start_pix, lfsr_seed, lfsr_q;
    logic                lfsr_sel;
    logic                load, advance;

    function automatic logic [DATA_W-1:0] ramp_pix(input logic [XW-1:0] rx, input logic [YW-1:0] ry);
        logic [CH_W-1:0] r, g, b;
        r = CH_W'(rx);
        g = CH_W'(ry);
        b = r + g;
        return {r, g, b};
    endfunction

    always_comb begin
        nx = x + XW'(1);
        ny = y;
        if (x == X_LAST) begin
            nx = '0;
            ny = y + YW'(1);
        end
    end

    // For CONST the register simply holds the seed; for COUNT it is the count itself.
    always_comb begin
        next_pix = pix_q;
        unique case (mode_q)
            MODE_COUNT: next_pix = (pix_q == CNT_LAST) ? '0 : pix_q + DATA_W'(1);
            MODE_RAMP:  next_pix = ramp_pix(nx, ny);
            MODE_CONST: next_pix = pix_q;
            MODE_LFSR:  next_pix = '0;
        endcase
    end

    assign start_pix = (mode_e'(mode) == MODE_CONST) ? seed : '0;
    assign lfsr_seed = (seed == '0) ? DATA_W'(1) : seed;
    assign load      = (state == IDLE) && start;
    assign advance   = (state == RUN) && out_ready && !eof;

    pixel_lfsr #(
        .DATA_W    (DATA_W),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (lfsr_seed),
        .advance  (advance),
        .q        (lfsr_q)
    );

    // Both sources are flops; lfsr_sel is only set while an LFSR frame is valid.
    assign d_out = lfsr_sel ? lfsr_q : pix_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mode_q     <= MODE_COUNT;
            x          <= '0;
            y          <= '0;
            pix_q      <= '0;
            lfsr_sel   <= 1'b0;
            d_valid    <= 1'b0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            eof        <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        mode_q   <= mode_e'(mode);
                        x        <= '0;
                        y        <= '0;
                        pix_q    <= start_pix;
                        lfsr_sel <= (mode_e'(mode) == MODE_LFSR);
                        d_valid  <= 1'b1;
                        sof      <= 1'b1;
                        eol      <= 1'b0;
                        eof      <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (eof) begin
                            state      <= DONE;
                            pix_q      <= '0;
                            lfsr_sel   <= 1'b0;
                            d_valid    <= 1'b0;
                            sof        <= 1'b0;
                            eol        <= 1'b0;
                            eof        <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            x     <= nx;
                            y     <= ny;
                            pix_q <= next_pix;
                            sof   <= 1'b0;
                            eol   <= (nx == X_LAST);
                            eof   <= (nx == X_LAST) && (ny == Y_LAST);
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    frame_done <= 1'b0;
                    x          <= '0;
                    y          <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Drives two differently-sized generators from shared stimulus and checks them against a frame-index model.
module tb_pixel_stream_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [23:0] seed;
    logic        out_ready;

    logic [23:0] a_d, b_d;
    logic        a_v, a_sof, a_eol, a_eof, a_busy, a_fd;
    logic        b_v, b_sof, b_eol, b_eof, b_busy, b_fd;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned fd_cnt_a = 0;

    // model state per DUT: 0 idle, 1 streaming, 2 done pulse
    int unsigned m_st[2];
    int unsigned m_k[2];
    int unsigned m_mode[2];
    logic [23:0] m_seed[2];
    logic [23:0] m_lf[2];
    int unsigned mw[2]   = '{4, 16};
    int unsigned mh[2]   = '{2, 16};
    int unsigned mmod[2] = '{4, 5};
    int unsigned cnt_tbl[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    always #5 clk = ~clk;

    pixel_stream_gen #(.CH_W(8), .IMG_W(4), .IMG_H(2), .CNT_MOD(4), .LFSR_TAPS(24'hE10000)) dut_a (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .out_ready(out_ready),
        .d_out(a_d), .d_valid(a_v), .sof(a_sof), .eol(a_eol), .eof(a_eof), .busy(a_busy),
        .frame_done(a_fd)
    );

    pixel_stream_gen #(.CH_W(8), .IMG_W(16), .IMG_H(16), .CNT_MOD(5), .LFSR_TAPS(24'hE10000)) dut_b (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .seed(seed), .out_ready(out_ready),
        .d_out(b_d), .d_valid(b_v), .sof(b_sof), .eol(b_eol), .eof(b_eof), .busy(b_busy),
        .frame_done(b_fd)
    );

    function automatic logic [23:0] lfsr_step(input logic [23:0] q);
        logic [23:0] taps;
        logic        fb;
        taps = 24'hE10000;
        fb = 1'b0;
        for (int i = 0; i < 24; i++) fb = fb ^ (q[i] & taps[i]);
        return {q[22:0], fb};
    endfunction

    function automatic logic [23:0] exp_pix(input int i);
        int unsigned px, py;
        px = m_k[i] % mw[i];
        py = m_k[i] / mw[i];
        case (m_mode[i])
            0:       return 24'(m_k[i] % mmod[i]);
            1:       return 24'(((px & 255) << 16) | ((py & 255) << 8) | ((px + py) & 255));
            2:       return m_seed[i];
            default: return m_lf[i];
        endcase
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t got %0h expected %0h", name, i, $time, act, exp);
        end
    endtask

    task automatic check_dut(input int i, input logic [23:0] d, input logic v, input logic sf,
                             input logic el, input logic ef, input logic bz, input logic fd);
        int unsigned last;
        last = mw[i] * mh[i] - 1;
        if (m_st[i] == 1) begin
            chk("d_valid", i, 32'(v), 1);
            chk("d_out", i, 32'(d), 32'(exp_pix(i)));
            chk("sof", i, 32'(sf), 32'(m_k[i] == 0));
            chk("eol", i, 32'(el), 32'((m_k[i] % mw[i]) == mw[i] - 1));
            chk("eof", i, 32'(ef), 32'(m_k[i] == last));
            chk("busy", i, 32'(bz), 1);
            chk("frame_done", i, 32'(fd), 0);
            if (i == 0 && m_mode[i] == 0 && m_k[i] < 8) chk("count_lit", i, 32'(d), cnt_tbl[m_k[i]]);
            if (i == 1 && m_mode[i] == 1 && m_k[i] == 255) begin
                chk("ramp_15_15", i, 32'(d), 32'h0F0F1E);
                chk("ramp_15_15_flags", i, {30'd0, el, ef}, 3);
            end
            if (i == 1 && m_mode[i] == 1 && m_k[i] == 19) chk("ramp_3_1", i, 32'(d), 32'h030104);
            if (m_mode[i] == 3 && m_seed[i] == 0 && m_k[i] < 3) chk("lfsr_lit", i, 32'(d), 32'(1) << m_k[i]);
            if (m_mode[i] == 2 && m_seed[i] == 24'hA5A5A5) chk("const_lit", i, 32'(d), 32'hA5A5A5);
        end else begin
            chk("d_valid", i, 32'(v), 0);
            chk("flags_idle", i, {29'd0, sf, el, ef}, 0);
            chk("busy", i, 32'(bz), 0);
            chk("frame_done", i, 32'(fd), 32'(m_st[i] == 2));
        end
    endtask

    task automatic check_zero(input string name);
        chk(name, 0, {a_d, 2'b0, a_v, a_sof, a_eol, a_eof, a_busy, a_fd}, 0);
        chk(name, 1, {b_d, 2'b0, b_v, b_sof, b_eol, b_eof, b_busy, b_fd}, 0);
    endtask

    task automatic adv(input int i);
        if (!rst) begin
            m_st[i] = 0;
            m_k[i] = 0;
        end else begin
            case (m_st[i])
                0: if (start) begin
                    m_st[i] = 1;
                    m_k[i] = 0;
                    m_mode[i] = int'(mode);
                    m_seed[i] = seed;
                    m_lf[i] = (seed == 0) ? 24'd1 : seed;
                end
                1: if (out_ready) begin
                    if (m_k[i] == mw[i] * mh[i] - 1) m_st[i] = 2;
                    else begin
                        m_k[i]++;
                        m_lf[i] = lfsr_step(m_lf[i]);
                    end
                end
                default: m_st[i] = 0;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        adv(0);
        adv(1);
        @(negedge clk);
        if (a_fd) fd_cnt_a++;
        check_dut(0, a_d, a_v, a_sof, a_eol, a_eof, a_busy, a_fd);
        check_dut(1, b_d, b_v, b_sof, b_eol, b_eof, b_busy, b_fd);
    endtask

    task automatic pulse(input logic [1:0] md, input logic [23:0] sd);
        start = 1'b1;
        mode = md;
        seed = sd;
        step();
        start = 1'b0;
    endtask

    task automatic run_idle(input int unsigned maxc);
        int unsigned n;
        n = 0;
        while ((m_st[0] != 0 || m_st[1] != 0) && n < maxc) begin
            step();
            n++;
        end
        vectors++;
        if (n >= maxc) begin
            miscompares++;
            $display("FAIL frame_timeout got %0d cycles limit %0d", n, maxc);
        end
    endtask

    // Called at a negedge: reset lands between clock edges.
    task automatic async_reset();
        #1 rst = 1'b0;
        #1 check_zero("async_reset");
        m_st = '{0, 0};
        m_k = '{0, 0};
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        mode = 2'd0;
        seed = 24'd0;
        out_ready = 1'b1;
        m_st = '{0, 0};
        m_k = '{0, 0};
        m_mode = '{0, 0};
        m_seed = '{24'd0, 24'd0};
        m_lf = '{24'd1, 24'd1};
        step();
        check_zero("reset_state");
        step();
        rst = 1'b1;
        step();

        // COUNT frame at full rate
        pulse(2'd0, 24'd0);
        run_idle(1000);

        // backpressure held at pixel 2
        pulse(2'd0, 24'd0);
        step();
        step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        run_idle(1000);

        pulse(2'd1, 24'd0);
        run_idle(1000);
        pulse(2'd3, 24'd0);
        run_idle(1000);
        pulse(2'd2, 24'hA5A5A5);
        run_idle(1000);

        // start ignored mid-frame and during the done cycle
        fd_cnt_a = 0;
        pulse(2'd1, 24'h123456);
        step();
        pulse(2'd3, 24'h00BEEF);
        for (int n = 0; n < 100 && m_st[0] != 2; n++) step();
        pulse(2'd2, 24'h777777);
        run_idle(1000);
        chk("one_frame_done", 0, fd_cnt_a, 1);

        // async reset mid-frame, then a clean restart
        pulse(2'd0, 24'd0);
        repeat (3) step();
        async_reset();
        step();
        pulse(2'd0, 24'd0);
        chk("restart_sof", 0, {31'd0, a_sof}, 1);
        chk("restart_pix0", 0, 32'(a_d), 0);
        run_idle(1000);

        for (int c = 0; c < 3000; c++) begin
            start = ($urandom % 6) == 0;
            mode = 2'($urandom % 4);
            seed = (($urandom % 4) == 0) ? 24'd0 : 24'($urandom);
            out_ready = ($urandom % 4) != 0;
            if (($urandom % 500) == 0) async_reset();
            else step();
        end
        start = 1'b0;
        out_ready = 1'b1;
        run_idle(2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
